// File: rtl/cp0_intc_pkg.sv
// Shared CP0 definitions: register numbers, SR/Cause field layout, ExcCodes.
// Packs the stored SR/Cause fields into their architectural 32-bit views.
package cp0_pkg;

    localparam logic [4:0] CP0_SR    = 5'd12;
    localparam logic [4:0] CP0_CAUSE = 5'd13;
    localparam logic [4:0] CP0_EPC   = 5'd14;
    localparam logic [4:0] CP0_PRID  = 5'd15;

    localparam int SR_IE       = 0;
    localparam int SR_EXL      = 1;
    localparam int SR_IM_LO    = 10;
    localparam int SR_IM_HI    = 15;
    localparam int CAUSE_EX_LO = 2;
    localparam int CAUSE_EX_HI = 6;
    localparam int CAUSE_IP_LO = 10;
    localparam int CAUSE_IP_HI = 15;
    localparam int CAUSE_BD    = 31;

    localparam logic [4:0] EXC_INT  = 5'd0;
    localparam logic [4:0] EXC_ADEL = 5'd4;
    localparam logic [4:0] EXC_ADES = 5'd5;
    localparam logic [4:0] EXC_RI   = 5'd10;
    localparam logic [4:0] EXC_OV   = 5'd12;

    typedef struct packed {
        logic [5:0] im;
        logic       exl;
        logic       ie;
    } sr_t;

    typedef struct packed {
        logic       bd;
        logic [5:0] ip;
        logic [4:0] exc;
    } cause_t;

    function automatic logic [31:0] sr_word(input sr_t s);
        logic [31:0] w;
        w = '0;
        w[SR_IM_HI:SR_IM_LO] = s.im;
        w[SR_EXL]            = s.exl;
        w[SR_IE]             = s.ie;
        return w;
    endfunction

    function automatic logic [31:0] cause_word(input cause_t c);
        logic [31:0] w;
        w = '0;
        w[CAUSE_BD]                = c.bd;
        w[CAUSE_IP_HI:CAUSE_IP_LO] = c.ip;
        w[CAUSE_EX_HI:CAUSE_EX_LO] = c.exc;
        return w;
    endfunction

endpackage

// File: rtl/cp0_irq_arb.sv
// Combinational interrupt/exception arbitration; a pending interrupt beats a
// simultaneous synchronous exception and reports ExcCode Int.
module cp0_irq_arb
    import cp0_pkg::*;
(
    input  logic [5:0] hw_int_i,
    input  logic [5:0] im_i,
    input  logic       ie_i,
    input  logic       exl_i,
    input  logic [4:0] exc_code_i,
    output logic       irq_o,
    output logic       exc_o,
    output logic       int_req_o,
    output logic [4:0] code_o
);

    assign irq_o     = (|(hw_int_i & im_i)) & ie_i & ~exl_i;
    assign exc_o     = (exc_code_i != EXC_INT) & ~exl_i;
    assign int_req_o = irq_o | exc_o;
    assign code_o    = irq_o ? EXC_INT : exc_code_i;

endmodule

// File: rtl/cp0_intc.sv
// CP0 interrupt/exception controller: SR, Cause, EPC, PRId beside the M stage.
// Define CP0_BD_EN to track branch-delay slots (Cause.BD and EPC = pc-4).
module cp0_intc
    import cp0_pkg::*;
#(
    parameter logic [31:0] PRID = 32'h0000_B0A8
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        we,
    input  logic [4:0]  addr,
    input  logic [31:0] wd,
    output logic [31:0] rd,
    input  logic [31:0] pc,
    input  logic        bd,
    input  logic [4:0]  exc_code,
    input  logic [5:0]  hw_int,
    input  logic        exl_clr,
    output logic        int_req,
    output logic [31:0] epc
);

    sr_t         sr_q, sr_d;
    cause_t      cause_q, cause_d;
    logic [31:0] epc_q, epc_d;

    logic        irq, exc;
    logic [4:0]  sel_code;
    logic        bd_eff;
    logic [31:0] epc_tgt;

    cp0_irq_arb u_arb (
        .hw_int_i   (hw_int),
        .im_i       (sr_q.im),
        .ie_i       (sr_q.ie),
        .exl_i      (sr_q.exl),
        .exc_code_i (exc_code),
        .irq_o      (irq),
        .exc_o      (exc),
        .int_req_o  (int_req),
        .code_o     (sel_code)
    );

`ifdef CP0_BD_EN
    assign bd_eff  = bd;
    assign epc_tgt = bd ? (pc - 32'd4) : pc;
`else
    logic unused_bd;
    assign unused_bd = bd;
    assign bd_eff    = 1'b0;
    assign epc_tgt   = pc;
`endif

    always_comb begin
        sr_d     = sr_q;
        cause_d  = cause_q;
        epc_d    = epc_q;
        cause_d.ip = hw_int;
        if (int_req) begin
            // taking the trap wins over any mtc0/eret in the same cycle
            sr_d.exl    = 1'b1;
            cause_d.bd  = bd_eff;
            cause_d.exc = sel_code;
            epc_d       = epc_tgt & 32'hFFFF_FFFC;
        end else begin
            if (we) begin
                case (addr)
                    CP0_SR: begin
                        sr_d.im  = wd[SR_IM_HI:SR_IM_LO];
                        sr_d.exl = wd[SR_EXL];
                        sr_d.ie  = wd[SR_IE];
                    end
                    CP0_EPC: epc_d = wd & 32'hFFFF_FFFC;
                    default: ;
                endcase
            end
            if (exl_clr) sr_d.exl = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            sr_q    <= '0;
            cause_q <= '0;
            epc_q   <= '0;
        end else begin
            sr_q    <= sr_d;
            cause_q <= cause_d;
            epc_q   <= epc_d;
        end
    end

    always_comb begin
        rd = '0;
        case (addr)
            CP0_SR:    rd = sr_word(sr_q);
            CP0_CAUSE: rd = cause_word(cause_q);
            CP0_EPC:   rd = epc_q;
            CP0_PRID:  rd = PRID;
            default:   rd = '0;
        endcase
    end

    assign epc = epc_q;

endmodule

// File: tb/tb_cp0_intc.sv
// Scoreboard bench for cp0_intc: directed steps push expected rd/int_req,
// a negedge monitor pops and compares against the DUT.
module tb_cp0_intc;

`ifdef CP0_BD_EN
    localparam bit BD_EN = 1'b1;
`else
    localparam bit BD_EN = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        reset;
    logic        we;
    logic [4:0]  addr;
    logic [31:0] wd;
    logic [31:0] rd;
    logic [31:0] pc;
    logic        bd;
    logic [4:0]  exc_code;
    logic [5:0]  hw_int;
    logic        exl_clr;
    logic        int_req;
    logic [31:0] epc;

    cp0_intc #(.PRID(32'h0000_B0A8)) dut (
        .clk      (clk),
        .reset    (reset),
        .we       (we),
        .addr     (addr),
        .wd       (wd),
        .rd       (rd),
        .pc       (pc),
        .bd       (bd),
        .exc_code (exc_code),
        .hw_int   (hw_int),
        .exl_clr  (exl_clr),
        .int_req  (int_req),
        .epc      (epc)
    );

    always #5 clk = ~clk;

    typedef struct {
        string       name;
        logic [4:0]  addr;
        logic [31:0] rd;
        logic        irq;
    } exp_t;

    exp_t sb[$];
    logic chk_vld = 1'b0;
    int   checks  = 0;
    int   errors  = 0;

    always @(negedge clk) begin
        if (chk_vld) begin
            if (sb.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL scoreboard_underflow: check strobe with empty queue");
            end else begin
                exp_t e;
                e = sb.pop_front();
                checks++;
                if (rd !== e.rd) begin
                    errors++;
                    $display("FAIL %s rd: got %h expected %h", e.name, rd, e.rd);
                end
                checks++;
                if (int_req !== e.irq) begin
                    errors++;
                    $display("FAIL %s int_req: got %b expected %b", e.name, int_req, e.irq);
                end
                if (e.addr == 5'd14) begin
                    checks++;
                    if (epc !== e.rd) begin
                        errors++;
                        $display("FAIL %s epc: got %h expected %h", e.name, epc, e.rd);
                    end
                end
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Drive one cycle of inputs, queue the expected response, then cross the edge.
    task automatic step(input logic w, input logic [4:0] a, input logic [31:0] d,
                        input logic [5:0] h, input logic [4:0] e, input logic [31:0] p,
                        input logic b, input logic c, input string n,
                        input logic [31:0] erd, input logic eirq);
        exp_t x;
        we = w; addr = a; wd = d; hw_int = h; exc_code = e; pc = p; bd = b; exl_clr = c;
        x.name = n; x.addr = a; x.rd = erd; x.irq = eirq;
        sb.push_back(x);
        chk_vld = 1'b1;
        @(negedge clk);
        #1;
        chk_vld = 1'b0;
        tick();
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    initial begin
        reset = 1'b1; we = 0; addr = 0; wd = 0; pc = 0; bd = 0;
        exc_code = 0; hw_int = 0; exl_clr = 0;
        tick(); tick();
        reset = 1'b0;

        step(0, 12, 0, 0, 0, 0, 0, 0, "rst_sr",       32'h0, 0);
        step(0, 13, 0, 0, 0, 0, 0, 0, "rst_cause",    32'h0, 0);
        step(0, 14, 0, 0, 0, 0, 0, 0, "rst_epc",      32'h0, 0);
        step(0, 15, 0, 0, 0, 0, 0, 0, "rst_prid",     32'h0000_B0A8, 0);
        step(0,  7, 0, 0, 0, 0, 0, 0, "rst_unmapped", 32'h0, 0);

        // enable IE/IM[10] with hw_int[0] already high
        step(1, 12, 32'h401, 6'd1, 0, 32'h3010, 0, 0, "sr_wr_old",  32'h0,    0);
        step(0, 12, 0,       6'd1, 0, 32'h3010, 0, 0, "irq_req",    32'h401,  1);
        step(0, 14, 0,       6'd1, 0, 32'h3010, 0, 0, "irq_epc",    32'h3010, 0);
        step(0, 13, 0,       6'd1, 0, 32'h3010, 0, 0, "irq_cause",  32'h400,  0);
        step(0, 12, 0,       6'd1, 0, 32'h3010, 0, 0, "irq_sr_exl", 32'h403,  0);
        step(0, 12, 0,       6'd1, 0, 32'h3010, 0, 1, "eret_cycle", 32'h403,  0);
        step(0, 12, 0,       6'd1, 0, 32'h3010, 0, 0, "eret_reirq", 32'h401,  1);
        step(1, 12, 0,       6'd0, 0, 32'h3010, 0, 0, "sr_clr_wr",  32'h403,  0);

        // synchronous overflow in a delay slot
        step(0, 13, 0, 0, 12, 32'h3024, 1, 0, "exc_req", 32'h0, 1);
        step(0, 14, 0, 0, 0, 0, 0, 0, "exc_epc",
             BD_EN ? 32'h0000_3020 : 32'h0000_3024, 0);
        step(0, 13, 0, 0, 0, 0, 0, 0, "exc_cause",
             BD_EN ? 32'h8000_0030 : 32'h0000_0030, 0);
        step(1, 12, 32'h403, 0, 0, 0, 0, 1, "we_clr_old", 32'h2,   0);
        step(0, 12, 0,       0, 0, 0, 0, 0, "we_clr_new", 32'h401, 0);

        // interrupt and AdEL together: interrupt wins
        step(0, 13, 0, 6'd1, 4, 32'h4000, 0, 0, "prio_req",
             BD_EN ? 32'h8000_0030 : 32'h0000_0030, 1);
        step(0, 13, 0, 0, 0, 0, 0, 0, "prio_cause", 32'h400,  0);
        step(0, 14, 0, 0, 0, 0, 0, 0, "prio_epc",   32'h4000, 0);
        step(0, 12, 0, 0, 0, 0, 0, 1, "prio_eret",  32'h403,  0);

        // mtc0 EPC coinciding with a trap is dropped
        step(1, 14, 32'h1234_5678, 0, 10, 32'h5008, 0, 0, "wr_drop_req", 32'h4000, 1);
        step(0, 14, 0, 0, 0, 0, 0, 0, "wr_drop_epc", 32'h5008, 0);
        step(0, 13, 0, 0, 0, 0, 0, 0, "ri_cause",    32'h28,   0);
        step(1, 14, 32'h1234_5678, 0, 0, 0, 0, 1, "epc_wr_old", 32'h5008, 0);
        step(0, 14, 0, 0, 0, 0, 0, 0, "epc_wr_new", 32'h1234_5678, 0);
        step(1, 14, 32'hFFFF_FFFF, 0, 0, 0, 0, 0, "epc_mask_old", 32'h1234_5678, 0);
        step(1, 13, 32'hFFFF_FFFF, 0, 0, 0, 0, 0, "cause_wr",  32'h28, 0);
        step(0, 14, 0, 0, 0, 0, 0, 0, "epc_mask",  32'hFFFF_FFFC, 0);
        step(0, 13, 0, 0, 0, 0, 0, 0, "cause_ro",  32'h28, 0);
        step(1, 15, 32'h0, 0, 0, 0, 0, 0, "prid_wr", 32'h0000_B0A8, 0);
        step(1,  7, 32'hFFFF_FFFF, 0, 0, 0, 0, 0, "unmapped_wr", 32'h0, 0);
        step(0, 12, 0, 0, 0, 0, 0, 0, "sr_after_nops", 32'h401, 0);

        // pc-4 wraps below zero in a delay slot; low bits forced to 0
        step(0, 12, 0, 0, 5, 32'h2, 1, 0, "wrap_req", 32'h401, 1);
        step(0, 14, 0, 0, 0, 0, 0, 0, "wrap_epc",
             BD_EN ? 32'hFFFF_FFFC : 32'h0, 0);
        step(0, 13, 0, 0, 0, 0, 0, 0, "wrap_cause",
             BD_EN ? 32'h8000_0014 : 32'h0000_0014, 0);

        // reset while in the handler
        reset = 1'b1; hw_int = 6'h3F; exc_code = 5'd12; pc = 32'h7000;
        tick();
        reset = 1'b0;
        step(0, 12, 0, 0, 0, 0, 0, 0, "rst2_sr",    32'h0, 0);
        step(0, 13, 0, 0, 0, 0, 0, 0, "rst2_cause", 32'h0, 0);
        step(0, 14, 0, 0, 0, 0, 0, 0, "rst2_epc",   32'h0, 0);
        step(0, 15, 0, 0, 0, 0, 0, 0, "rst2_prid",  32'h0000_B0A8, 0);

        for (int i = 0; i < 10 && sb.size() != 0; i++) tick();
        if (sb.size() != 0) begin
            checks++;
            errors++;
            $display("FAIL scoreboard_drain: %0d entries left, expected 0", sb.size());
        end
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
